wb_pipe_stage: RTL and testbench

- Parametrised MEM/WB pipeline register plus write-back select for the stalled pipelined CPU.
- Adds the following to the basic MEM/WB latch:
  - synchronous reset
  - stall hold and flush-to-bubble
  - a valid bit
  - single-shot register-file write qualification
  - optional r0 write suppression
  - a retired-instruction counter
- Sits between the MEM stage and the register-file write port. Its outputs also feed the forwarding and hazard unit and the debug display.

---
 rtl/wb_pipe_stage.sv | 81 ++++++++
 tb/tb_wb_pipe_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage: MEM/WB pipeline register with stall/flush, valid, single-shot write enable and retire counter
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   stall, flush             hold the WB register / load a bubble into it
//   mem_*                    MEM stage instruction fields captured into WB
//   MEM_ins_type/number      debug tags captured into WB
//   wb_valid, wb_wreg        WB holds a real instruction / qualified register-file write
//   wb_destR, wb_dest        registered destination and write-back data
//   WB_ins_type/number       registered debug tags
//   wb_retire, retire_cnt    fresh-load pulse and count of instructions loaded into WB
module wb_pipe_stage #(
    parameter int DATA_W        = 32,
    parameter int REG_AW        = 5,
    parameter int TAG_W         = 4,
    parameter int CNT_W         = 16,
    parameter bit ZERO_SUPPRESS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_wreg,
    input  logic              mem_m2reg,
    input  logic [DATA_W-1:0] mem_mdata,
    input  logic [DATA_W-1:0] mem_aluR,
    input  logic [REG_AW-1:0] mem_destR,
    input  logic [TAG_W-1:0]  MEM_ins_type,
    input  logic [TAG_W-1:0]  MEM_ins_number,
    output logic              wb_valid,
    output logic              wb_wreg,
    output logic [REG_AW-1:0] wb_destR,
    output logic [DATA_W-1:0] wb_dest,
    output logic [TAG_W-1:0]  WB_ins_type,
    output logic [TAG_W-1:0]  WB_ins_number,
    output logic              wb_retire,
    output logic [CNT_W-1:0]  retire_cnt
);
    logic              valid_r, new_r, wreg_r, m2reg_r;
    logic [DATA_W-1:0] mdata_r, aluR_r;
    logic [REG_AW-1:0] destR_r;
    logic [TAG_W-1:0]  type_r, number_r;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_r  <= 1'b0;
            new_r    <= 1'b0;
            wreg_r   <= 1'b0;
            m2reg_r  <= 1'b0;
            mdata_r  <= '0;
            aluR_r   <= '0;
            destR_r  <= '0;
            type_r   <= '0;
            number_r <= '0;
            if (rst)
                retire_cnt <= '0;
        end else if (stall) begin
            // holding keeps wb_dest stable for forwarding; only the fresh flag drops
            new_r <= 1'b0;
        end else begin
            valid_r  <= mem_valid;
            new_r    <= mem_valid;
            wreg_r   <= mem_wreg & mem_valid;
            m2reg_r  <= mem_m2reg;
            mdata_r  <= mem_mdata;
            aluR_r   <= mem_aluR;
            destR_r  <= mem_destR;
            type_r   <= MEM_ins_type;
            number_r <= MEM_ins_number;
            if (mem_valid)
                retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end
    assign wb_valid      = valid_r;
    assign wb_retire     = new_r;
    // gating with new_r makes the register-file write happen once per instruction however long it stalls
    assign wb_wreg       = wreg_r & new_r & (!ZERO_SUPPRESS || (|destR_r));
    assign wb_destR      = destR_r;
    assign wb_dest       = m2reg_r ? mdata_r : aluR_r;
    assign WB_ins_type   = type_r;
    assign WB_ins_number = number_r;
endmodule

// File: tb/tb_wb_pipe_stage.sv
// tb_wb_pipe_stage: directed and randomized check of wb_pipe_stage against an instruction-level model
module tb_wb_pipe_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush, mem_valid, mem_wreg, mem_m2reg;
    logic [31:0] mem_mdata, mem_aluR;
    logic [4:0]  mem_destR;
    logic [3:0]  mem_type, mem_number;

    logic        a_valid, a_wreg, a_retire, b_valid, b_wreg, b_retire;
    logic [4:0]  a_destR, b_destR;
    logic [31:0] a_dest, b_dest;
    logic [3:0]  a_type, a_number, b_type, b_number;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct packed {
        logic        valid, fresh, wreg, m2reg;
        logic [31:0] mdata, alu;
        logic [4:0]  dest;
        logic [3:0]  ty, nu;
    } wb_t;

    wb_t m;
    int  retired;

    always #5 clk = ~clk;

    wb_pipe_stage dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .mem_mdata(mem_mdata), .mem_aluR(mem_aluR), .mem_destR(mem_destR),
        .MEM_ins_type(mem_type), .MEM_ins_number(mem_number),
        .wb_valid(a_valid), .wb_wreg(a_wreg), .wb_destR(a_destR), .wb_dest(a_dest),
        .WB_ins_type(a_type), .WB_ins_number(a_number),
        .wb_retire(a_retire), .retire_cnt(a_cnt)
    );

    wb_pipe_stage #(.CNT_W(4), .ZERO_SUPPRESS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .mem_mdata(mem_mdata), .mem_aluR(mem_aluR), .mem_destR(mem_destR),
        .MEM_ins_type(mem_type), .MEM_ins_number(mem_number),
        .wb_valid(b_valid), .wb_wreg(b_wreg), .wb_destR(b_destR), .wb_dest(b_dest),
        .WB_ins_type(b_type), .WB_ins_number(b_number),
        .wb_retire(b_retire), .retire_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic compare_model();
        logic [31:0] d;
        d = m.m2reg ? m.mdata : m.alu;
        chk("a_valid",  64'(a_valid),  64'(m.valid));
        chk("a_wreg",   64'(a_wreg),   64'(m.wreg && m.fresh && m.dest != 0));
        chk("a_retire", 64'(a_retire), 64'(m.fresh));
        chk("a_destR",  64'(a_destR),  64'(m.dest));
        chk("a_dest",   64'(a_dest),   64'(d));
        chk("a_type",   64'(a_type),   64'(m.ty));
        chk("a_number", 64'(a_number), 64'(m.nu));
        chk("a_cnt",    64'(a_cnt),    64'(retired % 65536));
        chk("b_wreg",   64'(b_wreg),   64'(m.wreg && m.fresh));
        chk("b_dest",   64'(b_dest),   64'(d));
        chk("b_valid",  64'(b_valid),  64'(m.valid));
        chk("b_cnt",    64'(b_cnt),    64'(retired % 16));
    endtask

    task automatic step(input bit r, input bit f, input bit s, input bit v, input bit w,
                        input bit m2, input logic [31:0] md, input logic [31:0] al,
                        input logic [4:0] d);
        rst = r; flush = f; stall = s; mem_valid = v; mem_wreg = w; mem_m2reg = m2;
        mem_mdata = md; mem_aluR = al; mem_destR = d;
        mem_type = 4'($urandom); mem_number = 4'($urandom);
        @(posedge clk);
        if (r) begin
            m = '0;
            retired = 0;
        end else if (f)
            m = '0;
        else if (s)
            m.fresh = 1'b0;
        else begin
            m = '{v, v, w & v, m2, md, al, d, mem_type, mem_number};
            if (v) retired++;
        end
        #1;
        compare_model();
    endtask

    task automatic load(input bit v, input bit w, input bit m2, input logic [31:0] md,
                        input logic [31:0] al, input logic [4:0] d);
        step(0, 0, 0, v, w, m2, md, al, d);
    endtask

    initial begin
        m = '0;
        retired = 0;
        step(1, 0, 0, 1, 1, 1, $urandom, $urandom, 5'($urandom));
        step(1, 1, 1, 1, 1, 0, $urandom, $urandom, 5'($urandom));
        chk("rst_dest", 64'(a_dest), 64'h0);
        chk("rst_valid", 64'(a_valid), 64'h0);
        chk("rst_cnt", 64'(a_cnt), 64'h0);

        load(1, 1, 0, 32'h0, 32'h12345678, 5'd3);
        chk("A_dest", 64'(a_dest), 64'h12345678);
        chk("A_destR", 64'(a_destR), 64'd3);
        chk("A_wreg", 64'(a_wreg), 64'd1);
        load(1, 1, 1, 32'hDEADBEEF, 32'h0, 5'd4);
        chk("B_dest", 64'(a_dest), 64'hDEADBEEF);
        chk("B_destR", 64'(a_destR), 64'd4);
        chk("B_wreg", 64'(a_wreg), 64'd1);
        chk("B_cnt", 64'(a_cnt), 64'd2);

        load(1, 1, 0, 32'h0, 32'hA5A5A5A5, 5'd5);
        chk("S_wreg0", 64'(a_wreg), 64'd1);
        chk("S_retire0", 64'(a_retire), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 1, 1, $urandom, $urandom, 5'($urandom));
            chk("S_wreg", 64'(a_wreg), 64'd0);
            chk("S_retire", 64'(a_retire), 64'd0);
            chk("S_dest", 64'(a_dest), 64'hA5A5A5A5);
            chk("S_valid", 64'(a_valid), 64'd1);
        end
        chk("S_cnt", 64'(a_cnt), 64'd3);

        step(0, 1, 1, 1, 1, 0, $urandom, $urandom, 5'($urandom));
        chk("F_valid", 64'(a_valid), 64'd0);
        chk("F_wreg", 64'(a_wreg), 64'd0);
        chk("F_dest", 64'(a_dest), 64'd0);
        chk("F_cnt", 64'(a_cnt), 64'd3);

        load(1, 1, 0, 32'h0, 32'h55, 5'd0);
        chk("Z_wreg_a", 64'(a_wreg), 64'd0);
        chk("Z_retire_a", 64'(a_retire), 64'd1);
        chk("Z_wreg_b", 64'(b_wreg), 64'd1);

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            load(!(i == 4 || i == 9 || i == 15), 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
        chk("W_cnt_b", 64'(b_cnt), 64'd1);
        chk("W_cnt_a", 64'(a_cnt), 64'd17);
        step(0, 0, 1, 1, 1, 0, $urandom, $urandom, 5'($urandom));
        step(1, 0, 1, 1, 1, 0, $urandom, $urandom, 5'($urandom));
        chk("R_cnt_b", 64'(b_cnt), 64'd0);
        chk("R_valid_b", 64'(b_valid), 64'd0);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3,
                 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
